// File: rtl/door_motor_ctrl.sv
// Door motor controller: turns an open/close request into dead-time-separated
// motor drive commands, with limit-switch feedback, obstruction reversal and a latched fault.
module door_motor_ctrl #(
  parameter int DEAD_CYCLES = 4,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_action,
  input  logic       open_limit,
  input  logic       closed_limit,
  input  logic       obstruct,
  output logic       motor_open,
  output logic       motor_close,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_BRAKE   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] cnt;
  logic             rev, rev_nxt;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    nxt_state = cur_state;
    rev_nxt   = rev;
    if (cur_state != S_FAULT && open_limit && closed_limit) begin
      nxt_state = S_FAULT;
    end else begin
      unique case (cur_state)
        S_CLOSED: if (door_action) nxt_state = S_OPENING;
        S_OPEN:   if (!door_action && !obstruct) nxt_state = S_CLOSING;
        S_OPENING: begin
          if (open_limit)               nxt_state = S_BRAKE;
          else if (cnt == TRAVEL_LAST)  nxt_state = S_FAULT;
          else if (!door_action)        nxt_state = S_BRAKE;
        end
        S_CLOSING: begin
          if (closed_limit) begin
            nxt_state = S_BRAKE;
          end else if (obstruct) begin
            nxt_state = S_BRAKE;
            rev_nxt   = 1'b1;
          end else if (cnt == TRAVEL_LAST) begin
            nxt_state = S_FAULT;
          end else if (door_action) begin
            nxt_state = S_BRAKE;
          end
        end
        S_BRAKE: begin
          // Inputs only matter on the last dead-time cycle.
          if (cnt == DEAD_LAST) begin
            if (rev) begin
              rev_nxt   = 1'b0;
              nxt_state = open_limit ? S_OPEN : S_OPENING;
            end else if (door_action) begin
              nxt_state = open_limit ? S_OPEN : S_OPENING;
            end else if (closed_limit) begin
              nxt_state = S_CLOSED;
            end else if (!obstruct) begin
              nxt_state = S_CLOSING;
            end else begin
              nxt_state = open_limit ? S_OPEN : S_OPENING;
            end
          end
        end
        S_FAULT: nxt_state = S_FAULT;
        default: nxt_state = S_BRAKE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state   <= S_BRAKE;
      cnt         <= '0;
      rev         <= 1'b0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      rev         <= rev_nxt;
      if (nxt_state != cur_state) cnt <= '0;
      else if (cnt != '1)         cnt <= cnt + 1'b1;
      // Outputs decoded from the next state so they change on the same edge.
      motor_open  <= (nxt_state == S_OPENING);
      motor_close <= (nxt_state == S_CLOSING);
      fault       <= (nxt_state == S_FAULT);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Bench for door_motor_ctrl: directed scenarios then random inputs, each cycle
// compared against a behavioural model of the door's rules.
module tb_door_motor_ctrl;

  localparam int DEAD    = 4;
  localparam int TMO     = 20;
  localparam int CW      = 10;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int CLOSED = 0, OPENING = 1, OPEN = 2, CLOSING = 3, BRAKE = 4, FAULT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       door_action = 1'b0;
  logic       open_limit = 1'b0;
  logic       closed_limit = 1'b0;
  logic       obstruct = 1'b0;
  logic       motor_open, motor_close, fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Model: where the door is, how long it has been there, pending reversal.
  int m_pos = BRAKE;
  int m_age = 0;
  bit m_rev = 1'b0;

  door_motor_ctrl #(.DEAD_CYCLES(DEAD), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .door_action(door_action), .open_limit(open_limit),
    .closed_limit(closed_limit), .obstruct(obstruct), .motor_open(motor_open),
    .motor_close(motor_close), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(motor_open && motor_close)) else begin
        bad++;
        $error("FAIL mutex: motor_open=%0b motor_close=%0b required not both 1", motor_open, motor_close);
      end
    end
  end

  function automatic int settle_pos(bit want_open, bit at_open);
    return want_open ? (at_open ? OPEN : OPENING) : CLOSING;
  endfunction

  function automatic void model_step(bit r, bit da, bit ol, bit cl, bit ob);
    int  to;
    bit  travel_expired;
    if (!r) begin
      m_pos = BRAKE; m_age = 0; m_rev = 1'b0;
      return;
    end
    to = m_pos;
    travel_expired = (m_age + 1 >= TMO);
    if (m_pos != FAULT && ol && cl) to = FAULT;
    else if (m_pos == CLOSED) begin
      if (da) to = OPENING;
    end else if (m_pos == OPEN) begin
      if (!da && !ob) to = CLOSING;
    end else if (m_pos == OPENING) begin
      if (ol) to = BRAKE;
      else if (travel_expired) to = FAULT;
      else if (!da) to = BRAKE;
    end else if (m_pos == CLOSING) begin
      if (cl) to = BRAKE;
      else if (ob) begin to = BRAKE; m_rev = 1'b1; end
      else if (travel_expired) to = FAULT;
      else if (da) to = BRAKE;
    end else if (m_pos == BRAKE && m_age + 1 >= DEAD) begin
      if (m_rev) begin m_rev = 1'b0; to = settle_pos(1'b1, ol); end
      else if (da) to = settle_pos(1'b1, ol);
      else if (cl) to = CLOSED;
      else to = settle_pos(ob, ol);
    end
    if (to != m_pos) m_age = 0;
    else if (m_age < CNT_MAX) m_age++;
    m_pos = to;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, door_action, open_limit, closed_limit, obstruct);
    #1;
    check("state", int'(state), m_pos);
    check("motor_open", int'(motor_open), int'(m_pos == OPENING));
    check("motor_close", int'(motor_close), int'(m_pos == CLOSING));
    check("fault", int'(fault), int'(m_pos == FAULT));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(input int target, input int budget);
    int k;
    k = 0;
    while (m_pos != target && k < budget) begin tick(); k++; end
    check("wait_bound", int'(m_pos == target), 1);
  endtask

  initial begin
    int mo_high;

    // Open from closed.
    rst_n = 1'b0; closed_limit = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    for (int i = 0; i < DEAD - 1; i++) begin
      tick();
      check("rel_brake", int'(state), BRAKE);
    end
    tick();
    check("rel_closed", int'(state), CLOSED);
    door_action = 1'b1; closed_limit = 1'b0;
    tick();
    check("open_start", int'(motor_open), 1);
    ticks(9);
    open_limit = 1'b1;
    tick();
    check("open_brake", int'(state), BRAKE);
    ticks(DEAD);
    check("open_done", int'(state), OPEN);
    check("open_motor", int'(motor_open), 0);

    // Obstruction reversal.
    door_action = 1'b0; open_limit = 1'b0;
    tick();
    check("close_start", int'(motor_close), 1);
    ticks(2);
    obstruct = 1'b1;
    tick();
    check("obs_stop", int'(motor_close), 0);
    obstruct = 1'b0;
    ticks(DEAD);
    check("rev_open", int'(motor_open), 1);
    ticks(3);
    open_limit = 1'b1;
    tick();
    check("rev_brake", int'(state), BRAKE);
    ticks(DEAD);
    check("reclose", int'(state), CLOSING);
    open_limit = 1'b0;
    ticks(2);
    closed_limit = 1'b1;
    tick();
    ticks(DEAD);
    check("closed_again", int'(state), CLOSED);

    // Timeout while opening.
    closed_limit = 1'b0; door_action = 1'b1;
    mo_high = 0;
    for (int i = 0; i < 60 && m_pos != FAULT; i++) begin
      tick();
      if (motor_open) mo_high++;
    end
    check("tmo_len", mo_high, TMO);
    check("tmo_fault", int'(fault), 1);
    check("tmo_state", int'(state), FAULT);
    door_action = 1'b0; closed_limit = 1'b1;
    ticks(5);
    check("fault_hold", int'(fault), 1);
    rst_n = 1'b0;
    tick();
    check("fault_reset", int'(state), BRAKE);
    rst_n = 1'b1; closed_limit = 1'b0;

    // Limit and timeout on the same cycle.
    door_action = 1'b1;
    wait_pos(OPENING, 20);
    ticks(TMO - 1);
    open_limit = 1'b1;
    tick();
    check("tie_state", int'(state), BRAKE);
    check("tie_fault", int'(fault), 0);

    // Request reversal mid-travel.
    open_limit = 1'b0;
    wait_pos(OPENING, 20);
    ticks(4);
    door_action = 1'b0;
    tick();
    check("rr_brake", int'(motor_open), 0);
    ticks(DEAD);
    check("rr_close", int'(motor_close), 1);

    // Sensor conflict in CLOSED.
    closed_limit = 1'b1;
    tick();
    ticks(DEAD);
    check("sc_closed", int'(state), CLOSED);
    open_limit = 1'b1;
    tick();
    check("sc_state", int'(state), FAULT);
    check("sc_fault", int'(fault), 1);

    // Random traffic against the model.
    rst_n = 1'b0; open_limit = 1'b0; closed_limit = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) door_action = ~door_action;
      open_limit   = ($urandom_range(7) == 0);
      closed_limit = ($urandom_range(7) == 0);
      obstruct     = ($urandom_range(9) == 0);
      rst_n        = !(($urandom_range(199) == 0) || (m_pos == FAULT && $urandom_range(3) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/door_motor_ctrl.md
# door_motor_ctrl

Door motor controller that receives the `door_action` open/close request and turns it into motor drive commands. It closes the loop with the two travel limit switches and an obstruction sensor, enforces a dead time before any motor direction change, and reverses the door on obstruction while closing. It latches a fault when travel times out or the sensors are inconsistent.

## Interface
- `DEAD_CYCLES`, default 4: cycles with both motor outputs low in BRAKE (≥1).
- `TIMEOUT`, default 1000: maximum cycles of continuous travel in OPENING/CLOSING (≥2).
- `CNT_W`, default 10: cycle counter width. Must hold `max(TIMEOUT, DEAD_CYCLES) - 1`.
- `clk`, input, 1: clock; all logic on rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `door_action`, input, 1: request; 1 = door open wanted, 0 = door closed wanted.
- `open_limit`, input, 1: door fully open switch.
- `closed_limit`, input, 1: door fully closed switch.
- `obstruct`, input, 1: obstruction in doorway.
- `motor_open`, output, 1: drive motor in open direction.
- `motor_close`, output, 1: drive motor in close direction.
- `state`, output, 3: encoding CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, BRAKE=4, FAULT=5.
- `fault`, output, 1: high while in FAULT.

## Operation
- All outputs are registered.
  - `motor_open` = (state==OPENING).
  - `motor_close` = (state==CLOSING).
  - `fault` = (state==FAULT).
  - Both motor outputs are never high together.
- One counter `cnt` clears on every state change and increments each cycle otherwise. It saturates and does not wrap.
- Both limits high in any state other than FAULT → FAULT. This has top priority.
- **CLOSED:** `door_action`=1 → OPENING.
- **OPEN:** `door_action`=0 and `obstruct`=0 → CLOSING. With `obstruct`=1, stay in OPEN.
- **OPENING:** priority order:
  1. `open_limit` → BRAKE.
  2. `cnt`==TIMEOUT-1 → FAULT.
  3. `door_action`=0 → BRAKE.
  - `obstruct` is ignored.
- **CLOSING:** priority order:
  1. `closed_limit` → BRAKE.
  2. `obstruct` → BRAKE and set `rev`.
  3. `cnt`==TIMEOUT-1 → FAULT.
  4. `door_action`=1 → BRAKE.
- **BRAKE:** both motors off. At `cnt`==DEAD_CYCLES-1, decide the next state in this order:
  - `rev`=1 → OPENING, or OPEN if `open_limit`; `rev` clears.
  - `door_action`=1 → OPEN if `open_limit`, else OPENING.
  - `door_action`=0 and `closed_limit` → CLOSED.
  - `door_action`=0, `obstruct`=0 → CLOSING.
  - `door_action`=0, `obstruct`=1 → OPENING, or OPEN if `open_limit`.
- **FAULT:** motors off. The only exit is reset.
- **Reset** (`rst_n`=0 at an edge): state=BRAKE, `cnt`=0, `rev`=0, `motor_open`=0, `motor_close`=0, `fault`=0.
  - Reset mid-travel stops the motor on the next edge.
  - Position is re-derived from the limits after the dead time.

## Timing
- Input sampled at edge N → new state and motor outputs visible after edge N. Latency is 1 cycle; there is no input synchronizer in this block.
- BRAKE lasts exactly DEAD_CYCLES cycles. Every motor-on interval is separated by at least DEAD_CYCLES idle cycles, including the OPEN/CLOSED pass-through.
- With no limit, `motor_open`/`motor_close` is high for exactly TIMEOUT cycles. `fault` rises on the next cycle.
- A limit arriving on the same cycle as `cnt`==TIMEOUT-1 wins: the next state is BRAKE, not FAULT.
- After reset release: DEAD_CYCLES cycles in BRAKE, then the decision.
- A `door_action` toggle within BRAKE is only sampled at the decision cycle.

## Test plan
Parameters for all scenarios: DEAD_CYCLES=4, TIMEOUT=20.

- **Open from closed:** reset release with `closed_limit`=1, `door_action`=0 → state 4 for 4 cycles, then 0.
  - Raise `door_action` → `motor_open`=1 on the next cycle.
  - `open_limit`=1 after 10 cycles → 4 idle cycles → state 2, motors 0.
- **Obstruction reversal:** in CLOSING, `obstruct`=1 for 1 cycle → `motor_close` drops next cycle, 4 cycles BRAKE → `motor_open`=1 even though `door_action`=0 → on `open_limit`, BRAKE → then CLOSING again if `obstruct`=0.
- **Timeout:** OPENING with no limit → `motor_open` high exactly 20 cycles → `fault`=1, state=5, motors 0. Held until `rst_n`=0, after which state=4.
- **Limit vs timeout tie:** `open_limit` asserted on the 20th OPENING cycle → state 4, `fault` stays 0.
- **Request reversal mid-travel:** `door_action` 1→0 on the 5th OPENING cycle → 4 cycles with both motors 0 → `motor_close`=1. `motor_open` and `motor_close` are never both high; a checker asserts this on every cycle.
- **Sensor conflict:** `open_limit`=`closed_limit`=1 in CLOSED → next cycle state=5, `fault`=1.
